// File: rtl/colour_key_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// colour_key_ctrl_pkg
// Shared constants and types for the PS/2 colour-key controller:
//   - set-2 make codes for keys 1..8, Enter, break prefix and extended prefix
//   - the eight {R,G,B} colour constants
//   - the scan-code sequencer state type and the lookup result type
// -----------------------------------------------------------------------------
package colour_key_ctrl_pkg;

  // Set-2 make codes for the number row keys 1..8
  localparam logic [7:0] SC_KEY1  = 8'h16;
  localparam logic [7:0] SC_KEY2  = 8'h1E;
  localparam logic [7:0] SC_KEY3  = 8'h26;
  localparam logic [7:0] SC_KEY4  = 8'h25;
  localparam logic [7:0] SC_KEY5  = 8'h2E;
  localparam logic [7:0] SC_KEY6  = 8'h36;
  localparam logic [7:0] SC_KEY7  = 8'h3D;
  localparam logic [7:0] SC_KEY8  = 8'h3E;

  // Control codes
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Colours as {R,G,B}
  localparam logic [2:0] COLOUR_BLACK   = 3'b000;
  localparam logic [2:0] COLOUR_BLUE    = 3'b001;
  localparam logic [2:0] COLOUR_GREEN   = 3'b010;
  localparam logic [2:0] COLOUR_CYAN    = 3'b011;
  localparam logic [2:0] COLOUR_RED     = 3'b100;
  localparam logic [2:0] COLOUR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOUR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOUR_WHITE   = 3'b111;

  // Scan-code sequencer states: which prefix bytes precede the next byte
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } key_state_e;

  // Result of translating a scan code into a colour
  typedef struct packed {
    logic       hit;
    logic [2:0] colour;
  } colour_lookup_t;

  // True when a colour make code repeats the key that is already held
  function automatic logic is_typematic(input logic [7:0] code,
                                        input logic [7:0] held_code,
                                        input logic       held);
    return held && (code == held_code);
  endfunction

endpackage : colour_key_ctrl_pkg

// File: rtl/ps2_colour_lookup.sv
// -----------------------------------------------------------------------------
// ps2_colour_lookup
// Purely combinational translation of a make code into a colour.
// Ports:
//   code_i   [7:0]  scan code to translate
//   hit_o           1 when code_i is one of the eight colour keys
//   colour_o [2:0]  {R,G,B} colour for the key (000 when hit_o is 0)
// -----------------------------------------------------------------------------
module ps2_colour_lookup
  import colour_key_ctrl_pkg::*;
(
  input  logic [7:0] code_i,
  output logic       hit_o,
  output logic [2:0] colour_o
);

  colour_lookup_t result_s;

  // Map each number key onto its colour; everything else is a miss
  always_comb begin
    result_s = '{hit: 1'b0, colour: COLOUR_BLACK};
    case (code_i)
      SC_KEY1: result_s = '{hit: 1'b1, colour: COLOUR_BLACK};
      SC_KEY2: result_s = '{hit: 1'b1, colour: COLOUR_BLUE};
      SC_KEY3: result_s = '{hit: 1'b1, colour: COLOUR_GREEN};
      SC_KEY4: result_s = '{hit: 1'b1, colour: COLOUR_CYAN};
      SC_KEY5: result_s = '{hit: 1'b1, colour: COLOUR_RED};
      SC_KEY6: result_s = '{hit: 1'b1, colour: COLOUR_MAGENTA};
      SC_KEY7: result_s = '{hit: 1'b1, colour: COLOUR_YELLOW};
      SC_KEY8: result_s = '{hit: 1'b1, colour: COLOUR_WHITE};
      default: result_s = '{hit: 1'b0, colour: COLOUR_BLACK};
    endcase
  end

  assign hit_o    = result_s.hit;
  assign colour_o = result_s.colour;

endmodule : ps2_colour_lookup

// File: rtl/colour_key_ctrl.sv
// -----------------------------------------------------------------------------
// colour_key_ctrl
// Turns PS/2 scan-code bytes into a current colour selection and a
// req/ack draw request for the VGA plotting FSM.
// Ports:
//   clock              system clock, rising edge
//   resetn             synchronous active-low reset
//   scan_code   [7:0]  byte from the PS/2 receiver
//   scan_valid         one-cycle strobe qualifying scan_code
//   draw_ack           drawing FSM accepted the pending request
//   colour      [2:0]  currently selected {R,G,B}
//   draw_colour [2:0]  colour frozen for the pending draw
//   draw_req           draw request, held until draw_ack
//   key_held           a colour key is currently down
//   overrun            one-cycle pulse: Enter make dropped, request busy
// -----------------------------------------------------------------------------
module colour_key_ctrl
  import colour_key_ctrl_pkg::*;
#(
  parameter logic [7:0] ENTER_CODE   = SC_ENTER,
  parameter logic [7:0] BREAK_CODE   = SC_BREAK,
  parameter logic [7:0] EXT_CODE     = SC_EXT,
  parameter logic [2:0] RESET_COLOUR = COLOUR_BLACK
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       draw_ack,
  output logic [2:0] colour,
  output logic [2:0] draw_colour,
  output logic       draw_req,
  output logic       key_held,
  output logic       overrun
);

  key_state_e state_q, state_d;
  logic [2:0] colour_q, colour_d;
  logic [2:0] draw_colour_q, draw_colour_d;
  logic       draw_req_q, draw_req_d;
  logic       key_held_q, key_held_d;
  logic       overrun_q, overrun_d;
  logic [7:0] held_code_q, held_code_d;
  logic       enter_held_q, enter_held_d;

  logic       hit_s;
  logic [2:0] lut_colour_s;

  ps2_colour_lookup u_lookup (
    .code_i   (scan_code),
    .hit_o    (hit_s),
    .colour_o (lut_colour_s)
  );

  // Next-state logic: prefix sequencing, held-key tracking and draw handshake
  always_comb begin
    state_d       = state_q;
    colour_d      = colour_q;
    draw_colour_d = draw_colour_q;
    draw_req_d    = draw_req_q;
    key_held_d    = key_held_q;
    overrun_d     = 1'b0;
    held_code_d   = held_code_q;
    enter_held_d  = enter_held_q;

    // Ack retires the request; an Enter in the same cycle still sees the
    // old draw_req_q and is therefore counted as an overrun below.
    if (draw_ack && draw_req_q) begin
      draw_req_d = 1'b0;
    end else begin
      draw_req_d = draw_req_q;
    end

    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == BREAK_CODE) begin
            state_d = ST_BREAK;
          end else if (scan_code == EXT_CODE) begin
            state_d = ST_EXT;
          end else if (hit_s) begin
            // Typematic repeats of the held key are swallowed
            if (!is_typematic(scan_code, held_code_q, key_held_q)) begin
              colour_d    = lut_colour_s;
              held_code_d = scan_code;
              key_held_d  = 1'b1;
            end else begin
              colour_d    = colour_q;
            end
          end else if ((scan_code == ENTER_CODE) && !enter_held_q) begin
            enter_held_d = 1'b1;
            if (draw_req_q) begin
              overrun_d = 1'b1;
            end else begin
              draw_req_d    = 1'b1;
              draw_colour_d = colour_q;
            end
          end else begin
            // Enter repeat or unknown code: nothing to do
            state_d = ST_IDLE;
          end
        end
        ST_BREAK: begin
          state_d = ST_IDLE;
          if (is_typematic(scan_code, held_code_q, key_held_q)) begin
            key_held_d = 1'b0;
          end else if (scan_code == ENTER_CODE) begin
            enter_held_d = 1'b0;
          end else begin
            key_held_d = key_held_q;
          end
        end
        ST_EXT: begin
          // Extended keys carry no function; only track a following break
          if (scan_code == BREAK_CODE) begin
            state_d = ST_EXT_BREAK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BREAK: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      // Prefix states wait indefinitely for the next byte
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      colour_q      <= RESET_COLOUR;
      draw_colour_q <= RESET_COLOUR;
      draw_req_q    <= 1'b0;
      key_held_q    <= 1'b0;
      overrun_q     <= 1'b0;
      held_code_q   <= 8'h00;
      enter_held_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      colour_q      <= colour_d;
      draw_colour_q <= draw_colour_d;
      draw_req_q    <= draw_req_d;
      key_held_q    <= key_held_d;
      overrun_q     <= overrun_d;
      held_code_q   <= held_code_d;
      enter_held_q  <= enter_held_d;
    end
  end

  assign colour      = colour_q;
  assign draw_colour = draw_colour_q;
  assign draw_req    = draw_req_q;
  assign key_held    = key_held_q;
  assign overrun     = overrun_q;

endmodule : colour_key_ctrl

// File: tb/tb_colour_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_colour_key_ctrl
// Directed scenarios followed by randomized byte streams, all compared
// against a keyboard-level reference model that tracks pending prefix bytes
// in a queue and decodes colour keys by searching a key table.
// -----------------------------------------------------------------------------
module tb_colour_key_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       draw_ack;
  logic [2:0] colour;
  logic [2:0] draw_colour;
  logic       draw_req;
  logic       key_held;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  colour_key_ctrl dut (
    .clock       (clock),
    .resetn      (resetn),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .draw_ack    (draw_ack),
    .colour      (colour),
    .draw_colour (draw_colour),
    .draw_req    (draw_req),
    .key_held    (key_held),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  // Key table: position in the table is the colour value
  logic [7:0] key_map [8] = '{8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E};

  // Reference model state
  logic [2:0] m_colour, m_dcolour, m_hcode_col;
  logic [7:0] m_hcode;
  bit         m_req, m_held, m_enter, m_ovr;
  logic [7:0] pfx [$];

  function automatic int key_index(input logic [7:0] code);
    for (int i = 0; i < 8; i++) if (key_map[i] == code) return i;
    return -1;
  endfunction

  // Advance the model by one clock edge with the given inputs
  task automatic model_edge(input bit rn, input bit sv,
                            input logic [7:0] code, input bit ack);
    bit req_before, is_ext, is_brk;
    int idx;
    if (!rn) begin
      m_colour = 3'b000; m_dcolour = 3'b000; m_req = 0; m_held = 0;
      m_enter = 0; m_ovr = 0; m_hcode = 8'h00; pfx.delete();
      return;
    end
    m_ovr = 0;
    req_before = m_req;
    if (ack) m_req = 0;
    if (!sv) return;
    if (pfx.size() == 0 && (code == 8'hF0 || code == 8'hE0)) begin
      pfx.push_back(code);
    end else if (pfx.size() == 1 && pfx[0] == 8'hE0 && code == 8'hF0) begin
      pfx.push_back(code);
    end else begin
      is_ext = 0; is_brk = 0;
      foreach (pfx[i]) begin
        if (pfx[i] == 8'hE0) is_ext = 1;
        if (pfx[i] == 8'hF0) is_brk = 1;
      end
      pfx.delete();
      if (!is_ext) begin
        if (is_brk) begin
          if (m_held && code == m_hcode) m_held = 0;
          else if (code == 8'h5A) m_enter = 0;
        end else begin
          idx = key_index(code);
          if (idx >= 0) begin
            if (!(m_held && code == m_hcode)) begin
              m_colour = 3'(idx); m_hcode = code; m_held = 1;
            end
          end else if (code == 8'h5A && !m_enter) begin
            m_enter = 1;
            if (req_before) m_ovr = 1;
            else begin m_req = 1; m_dcolour = m_colour; end
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("colour",      8'(colour),      8'(m_colour));
    chk("draw_colour", 8'(draw_colour), 8'(m_dcolour));
    chk("draw_req",    8'(draw_req),    8'(m_req));
    chk("key_held",    8'(key_held),    8'(m_held));
    chk("overrun",     8'(overrun),     8'(m_ovr));
  endtask

  // Apply one cycle of inputs, then compare just after the edge
  task automatic step(input bit rn, input bit sv, input logic [7:0] code, input bit ack);
    resetn = rn; scan_valid = sv; scan_code = code; draw_ack = ack;
    model_edge(rn, sv, code, ack);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] code);
    step(1'b1, 1'b1, code, 1'b0);
  endtask

  initial begin
    logic [7:0] rc;
    int pick;
    resetn = 1'b0; scan_valid = 1'b0; scan_code = 8'h00; draw_ack = 1'b0;

    // Reset for two cycles
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_colour", 8'(colour), 8'h00);
    chk("rst_req", 8'(draw_req), 8'h00);
    chk("rst_held", 8'(key_held), 8'h00);
    chk("rst_ovr", 8'(overrun), 8'h00);

    // Colour select with typematic repeats
    send(8'h2E);
    chk("sel_red", 8'(colour), 8'h04);
    chk("sel_held", 8'(key_held), 8'h01);
    send(8'h2E); send(8'h2E);
    chk("rep_red", 8'(colour), 8'h04);
    send(8'hF0); send(8'h2E);
    chk("rel_held", 8'(key_held), 8'h00);
    chk("rel_colour", 8'(colour), 8'h04);

    // Draw handshake
    send(8'h3E); send(8'h5A);
    chk("req_up", 8'(draw_req), 8'h01);
    chk("req_col", 8'(draw_colour), 8'h07);
    send(8'h1E);
    chk("chg_col", 8'(colour), 8'h01);
    chk("frozen", 8'(draw_colour), 8'h07);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("ack_clr", 8'(draw_req), 8'h00);

    // Overrun and typematic Enter
    send(8'hF0); send(8'h5A); send(8'h5A);     // fresh request
    send(8'hF0); send(8'h5A); send(8'h5A);     // pending -> overrun
    chk("ovr_pulse", 8'(overrun), 8'h01);
    chk("ovr_req", 8'(draw_req), 8'h01);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovr_once", 8'(overrun), 8'h00);
    send(8'h5A);
    chk("ovr_rep", 8'(overrun), 8'h00);

    // Ack and Enter make in the same cycle
    send(8'hF0); send(8'h5A);
    step(1'b1, 1'b1, 8'h5A, 1'b1);
    chk("ackent_ovr", 8'(overrun), 8'h01);
    chk("ackent_req", 8'(draw_req), 8'h00);

    // Extended and unknown keys
    send(8'hE0); send(8'h2E);
    send(8'hE0); send(8'hF0); send(8'h16);
    send(8'h1C);
    send(8'h26);                                // back in IDLE: green
    chk("ext_idle", 8'(colour), 8'h02);

    // Reset mid-request
    send(8'hF0); send(8'h5A); send(8'h5A);
    chk("pre_rst_req", 8'(draw_req), 8'h01);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_req", 8'(draw_req), 8'h00);
    chk("mid_rst_col", 8'(colour), 8'h00);
    send(8'h5A);
    chk("post_rst_req", 8'(draw_req), 8'h01);
    chk("post_rst_col", 8'(draw_colour), 8'h00);

    // Randomized byte streams
    for (int n = 0; n < 600; n++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2, 3: rc = key_map[$urandom_range(0, 7)];
        4:          rc = 8'h5A;
        5:          rc = 8'hF0;
        6:          rc = 8'hE0;
        7:          rc = 8'h1C;
        default:    rc = 8'($urandom);
      endcase
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           rc, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_colour_key_ctrl
